// File: rtl/rezzmaster.sv
// Shared definitions for the issue scheduler.
// Holds the default reservation-station and functional-unit sizes, the FU
// numbering, the per-FU issue record and the latency clamp helper.
package rezzmaster;

  localparam int NUM_RS = 16;
  localparam int NUM_FU = 3;
  localparam int LAT_W  = 3;
  localparam int IDX_W  = $clog2(NUM_RS);
  localparam int PRD_W  = 6;
  localparam int CNT_W  = 3;

  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_MEM  = 2;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [PRD_W-1:0] prd;
  } issue_t;

  // Legal latencies are 1..4. A zero still needs one cycle in the unit, and
  // anything longer is capped at the deepest pipeline we model.
  function automatic logic [CNT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    logic [CNT_W-1:0] res;
    if (lat == '0) begin
      res = CNT_W'(1);
    end else if (lat > LAT_W'(4)) begin
      res = CNT_W'(4);
    end else begin
      res = CNT_W'(lat);
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Circular find-first.
// Ports:
//   mask  - request bits, one per reservation-station entry
//   ptr   - search start position
//   found - at least one mask bit set
//   idx   - first set bit at or after ptr, wrapping past N-1 to 0 (0 if none)
module rr_picker #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] pos;

  // Scan from the farthest offset down to offset 0 so the closest hit to
  // ptr is the last one written. N is a power of two, so W-bit addition
  // provides the wrap for free.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = ptr + W'(i);
      if (mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue scheduler: picks ready reservation-station entries for
// two ALU units (FU0, FU1) and one MEM unit (FU2) round-robin, and tracks each
// unit's remaining latency to raise writeback.
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   flush           - synchronous flush: kill this cycle's grants/writebacks
//   rs_valid/ready  - per-entry occupancy and operand readiness
//   rs_is_mem       - entry needs the MEM unit (otherwise an ALU)
//   rs_lat, rs_prd  - per-entry execution latency and destination tag
//   issue_valid/idx - per-FU grant and granted RS index (same cycle)
//   wb_valid/prd    - per-FU completion and its destination tag
//   fu_busy         - FU cannot accept an issue this cycle
module issue_scheduler #(
  parameter int NUM_RS = rezzmaster::NUM_RS,
  parameter int NUM_FU = rezzmaster::NUM_FU,
  parameter int LAT_W  = rezzmaster::LAT_W,
  localparam int IDX_W = $clog2(NUM_RS)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [NUM_RS-1:0]                       rs_valid,
  input  logic [NUM_RS-1:0]                       rs_ready,
  input  logic [NUM_RS-1:0]                       rs_is_mem,
  input  logic [NUM_RS-1:0][LAT_W-1:0]            rs_lat,
  input  logic [NUM_RS-1:0][rezzmaster::PRD_W-1:0] rs_prd,
  output logic [NUM_FU-1:0]                       issue_valid,
  output logic [NUM_FU-1:0][IDX_W-1:0]            issue_idx,
  output logic [NUM_FU-1:0]                       wb_valid,
  output logic [NUM_FU-1:0][rezzmaster::PRD_W-1:0] wb_prd,
  output logic [NUM_FU-1:0]                       fu_busy
);

  import rezzmaster::*;

  logic [NUM_RS-1:0] cand;
  logic [NUM_RS-1:0] alu_mask;
  logic [NUM_RS-1:0] alu_mask2;
  logic [NUM_RS-1:0] mem_mask;

  logic             alu1_found, alu2_found, mem_found;
  logic [IDX_W-1:0] alu1_idx, alu2_idx, mem_idx;

  logic [IDX_W-1:0] alu_ptr_reg, alu_ptr_next;
  logic [IDX_W-1:0] mem_ptr_reg, mem_ptr_next;

  logic [NUM_FU-1:0] fu_free;
  logic              allow;
  issue_t            issue_sel [NUM_FU];

  assign cand     = rs_valid & rs_ready;
  assign alu_mask = cand & ~rs_is_mem;
  assign mem_mask = cand & rs_is_mem;

  // The second ALU pick searches the same circular order with the first
  // winner removed, so it yields the next candidate after it.
  always_comb begin
    alu_mask2           = alu_mask;
    alu_mask2[alu1_idx] = 1'b0;
  end

  rr_picker #(.N(NUM_RS)) u_pick_alu1 (
    .mask  (alu_mask),
    .ptr   (alu_ptr_reg),
    .found (alu1_found),
    .idx   (alu1_idx)
  );

  rr_picker #(.N(NUM_RS)) u_pick_alu2 (
    .mask  (alu_mask2),
    .ptr   (alu_ptr_reg),
    .found (alu2_found),
    .idx   (alu2_idx)
  );

  rr_picker #(.N(NUM_RS)) u_pick_mem (
    .mask  (mem_mask),
    .ptr   (mem_ptr_reg),
    .found (mem_found),
    .idx   (mem_idx)
  );

  // Nothing may issue while reset is held or a flush is in progress.
  assign allow = ~rst & ~flush;

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      issue_sel[f] = '0;
    end
    alu_ptr_next = alu_ptr_reg;
    mem_ptr_next = mem_ptr_reg;

    if (allow) begin
      if (alu1_found) begin
        if (fu_free[FU_ALU0]) begin
          issue_sel[FU_ALU0].valid = 1'b1;
          issue_sel[FU_ALU0].idx   = alu1_idx;
          issue_sel[FU_ALU0].prd   = rs_prd[alu1_idx];
          alu_ptr_next             = alu1_idx + 1'b1;
          if (fu_free[FU_ALU1] && alu2_found) begin
            issue_sel[FU_ALU1].valid = 1'b1;
            issue_sel[FU_ALU1].idx   = alu2_idx;
            issue_sel[FU_ALU1].prd   = rs_prd[alu2_idx];
            alu_ptr_next             = alu2_idx + 1'b1;
          end
        end else if (fu_free[FU_ALU1]) begin
          // FU0 is busy, so the first candidate falls to FU1 instead.
          issue_sel[FU_ALU1].valid = 1'b1;
          issue_sel[FU_ALU1].idx   = alu1_idx;
          issue_sel[FU_ALU1].prd   = rs_prd[alu1_idx];
          alu_ptr_next             = alu1_idx + 1'b1;
        end
      end

      if (mem_found && fu_free[FU_MEM]) begin
        issue_sel[FU_MEM].valid = 1'b1;
        issue_sel[FU_MEM].idx   = mem_idx;
        issue_sel[FU_MEM].prd   = rs_prd[mem_idx];
        mem_ptr_next            = mem_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ptr_reg <= '0;
      mem_ptr_reg <= '0;
    end else if (flush) begin
      alu_ptr_reg <= '0;
      mem_ptr_reg <= '0;
    end else begin
      alu_ptr_reg <= alu_ptr_next;
      mem_ptr_reg <= mem_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [PRD_W-1:0] tag_reg, tag_next;

      // cnt == 1 means the op completes this cycle, so the unit can take a
      // new op back-to-back.
      assign fu_free[gi] = (cnt_reg <= CNT_W'(1));
      assign fu_busy[gi] = ~fu_free[gi];

      assign issue_valid[gi] = issue_sel[gi].valid;
      assign issue_idx[gi]   = issue_sel[gi].idx;
      assign wb_valid[gi]    = (cnt_reg == CNT_W'(1)) & ~flush;
      assign wb_prd[gi]      = tag_reg;

      always_comb begin
        cnt_next = cnt_reg;
        tag_next = tag_reg;
        if (flush) begin
          cnt_next = '0;
          tag_next = '0;
        end else if (issue_sel[gi].valid) begin
          cnt_next = clamp_lat(rs_lat[issue_sel[gi].idx]);
          tag_next = issue_sel[gi].prd;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          tag_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
          tag_reg <= tag_next;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed testbench for issue_scheduler. The bench plays the role of the
// reservation station: it clears granted entries itself after each grant.
module tb_issue_scheduler;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [15:0]       rs_valid;
  logic [15:0]       rs_ready;
  logic [15:0]       rs_is_mem;
  logic [15:0][2:0]  rs_lat;
  logic [15:0][5:0]  rs_prd;
  logic [2:0]        issue_valid;
  logic [2:0][3:0]   issue_idx;
  logic [2:0]        wb_valid;
  logic [2:0][5:0]   wb_prd;
  logic [2:0]        fu_busy;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .rs_valid    (rs_valid),
    .rs_ready    (rs_ready),
    .rs_is_mem   (rs_is_mem),
    .rs_lat      (rs_lat),
    .rs_prd      (rs_prd),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .wb_valid    (wb_valid),
    .wb_prd      (wb_prd),
    .fu_busy     (fu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rs();
    rs_valid  = '0;
    rs_ready  = '0;
    rs_is_mem = '0;
    rs_lat    = '0;
    rs_prd    = '0;
  endtask

  task automatic set_entry(input int idx, input logic mem, input logic [2:0] lat,
                           input logic [5:0] prd);
    rs_valid[idx]  = 1'b1;
    rs_ready[idx]  = 1'b1;
    rs_is_mem[idx] = mem;
    rs_lat[idx]    = lat;
    rs_prd[idx]    = prd;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    clear_rs();

    // Reset state, with a candidate present that must not issue.
    set_entry(3, 1'b0, 3'd1, 6'd10);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_iv",   32'(issue_valid), 32'h0);
    chk("rst_idx",  32'(issue_idx),   32'h0);
    chk("rst_wb",   32'(wb_valid),    32'h0);
    chk("rst_prd",  32'(wb_prd),      32'h0);
    chk("rst_busy", 32'(fu_busy),     32'h0);

    // First cycle after reset: entries 3 and 7 go to FU0 and FU1.
    next_cycle();
    rst = 1'b0;
    set_entry(7, 1'b0, 3'd1, 6'd11);
    #2;
    chk("dual_iv",  32'(issue_valid), 32'h3);
    chk("dual_idx", 32'(issue_idx),   32'h073);
    next_cycle();
    clear_rs();
    #2;
    chk("dual_wb",   32'(wb_valid),  32'h3);
    chk("dual_prd0", 32'(wb_prd[0]), 32'd10);
    chk("dual_prd1", 32'(wb_prd[1]), 32'd11);
    chk("dual_busy", 32'(fu_busy),   32'h0);
    next_cycle();
    #2;
    chk("dual_wb_off", 32'(wb_valid), 32'h0);

    // Round robin: alu_ptr is 8, so the search wraps to entries 0 and 1.
    next_cycle();
    set_entry(0, 1'b0, 3'd3, 6'd20);
    set_entry(1, 1'b0, 3'd3, 6'd21);
    set_entry(2, 1'b0, 3'd3, 6'd22);
    #2;
    chk("rr_iv",  32'(issue_valid), 32'h3);
    chk("rr_idx", 32'(issue_idx),   32'h010);
    next_cycle();
    rs_valid[0] = 1'b0;
    rs_valid[1] = 1'b0;
    #2;
    chk("rr_iv_hold1", 32'(issue_valid), 32'h0);
    chk("rr_busy",     32'(fu_busy),     32'h3);
    next_cycle();
    #2;
    chk("rr_iv_hold2", 32'(issue_valid), 32'h0);
    next_cycle();
    #2;
    chk("rr_iv2",   32'(issue_valid), 32'h1);
    chk("rr_idx2",  32'(issue_idx),   32'h002);
    chk("rr_wb",    32'(wb_valid),    32'h3);
    chk("rr_prd0",  32'(wb_prd[0]),   32'd20);
    chk("rr_prd1",  32'(wb_prd[1]),   32'd21);
    next_cycle();
    clear_rs();
    #2;
    chk("rr_busy2", 32'(fu_busy),  32'h1);
    chk("rr_wb2",   32'(wb_valid), 32'h0);
    repeat (3) next_cycle();

    // MEM: long op on entry 5 blocks entry 6 until its writeback cycle.
    next_cycle();
    set_entry(5, 1'b1, 3'd4, 6'd40);
    #2;
    chk("mem_iv",  32'(issue_valid), 32'h4);
    chk("mem_idx", 32'(issue_idx),   32'h500);
    next_cycle();
    clear_rs();
    set_entry(6, 1'b1, 3'd1, 6'd41);
    #2;
    chk("mem_wait1", 32'(issue_valid), 32'h0);
    chk("mem_busy",  32'(fu_busy),     32'h4);
    next_cycle();
    #2;
    chk("mem_wait2", 32'(issue_valid), 32'h0);
    next_cycle();
    #2;
    chk("mem_wait3", 32'(issue_valid), 32'h0);
    chk("mem_busy3", 32'(fu_busy),     32'h4);
    next_cycle();
    #2;
    chk("mem_iv2",  32'(issue_valid), 32'h4);
    chk("mem_idx2", 32'(issue_idx),   32'h600);
    chk("mem_wb",   32'(wb_valid),    32'h4);
    chk("mem_prd",  32'(wb_prd[2]),   32'd40);
    next_cycle();
    clear_rs();
    #2;
    chk("mem_wb2",  32'(wb_valid),  32'h4);
    chk("mem_prd2", 32'(wb_prd[2]), 32'd41);

    // Latency clamp: lat 0 behaves as 1, lat 7 behaves as 4. alu_ptr is 3.
    next_cycle();
    set_entry(4, 1'b0, 3'd0, 6'd50);
    set_entry(9, 1'b0, 3'd7, 6'd51);
    #2;
    chk("lat_iv",  32'(issue_valid), 32'h3);
    chk("lat_idx", 32'(issue_idx),   32'h094);
    next_cycle();
    clear_rs();
    #2;
    chk("lat0_wb",   32'(wb_valid),  32'h1);
    chk("lat0_prd",  32'(wb_prd[0]), 32'd50);
    chk("lat7_busy", 32'(fu_busy),   32'h2);
    next_cycle();
    #2;
    chk("lat_wb_c2", 32'(wb_valid), 32'h0);
    next_cycle();
    #2;
    chk("lat_wb_c3", 32'(wb_valid), 32'h0);
    next_cycle();
    #2;
    chk("lat7_wb",  32'(wb_valid),  32'h2);
    chk("lat7_prd", 32'(wb_prd[1]), 32'd51);

    // Flush: FU0 holds a lat-3 op, entry 9 is ready, flush wins. alu_ptr is 10.
    next_cycle();
    set_entry(10, 1'b0, 3'd3, 6'd55);
    #2;
    chk("fl_pre_iv",  32'(issue_valid), 32'h1);
    chk("fl_pre_idx", 32'(issue_idx),   32'h00a);
    next_cycle();
    clear_rs();
    set_entry(9, 1'b0, 3'd2, 6'd60);
    flush = 1'b1;
    #2;
    chk("fl_busy_in", 32'(fu_busy),     32'h1);
    chk("fl_iv",      32'(issue_valid), 32'h0);
    chk("fl_idx",     32'(issue_idx),   32'h0);
    chk("fl_wb",      32'(wb_valid),    32'h0);
    next_cycle();
    flush = 1'b0;
    #2;
    chk("fl_busy_after", 32'(fu_busy),     32'h0);
    chk("fl_iv_after",   32'(issue_valid), 32'h1);
    chk("fl_idx_after",  32'(issue_idx),   32'h009);
    next_cycle();
    clear_rs();
    #2;
    chk("fl2_busy", 32'(fu_busy), 32'h1);
    next_cycle();
    flush = 1'b1;
    #2;
    chk("fl2_wb_kill", 32'(wb_valid), 32'h0);
    next_cycle();
    flush = 1'b0;
    #2;
    chk("fl2_busy_after", 32'(fu_busy), 32'h0);

    // Asynchronous reset pulse in the middle of execution. alu_ptr is 0.
    next_cycle();
    set_entry(1, 1'b0, 3'd4, 6'd61);
    #2;
    chk("ar_iv",  32'(issue_valid), 32'h1);
    chk("ar_idx", 32'(issue_idx),   32'h001);
    next_cycle();
    clear_rs();
    set_entry(2, 1'b0, 3'd1, 6'd62);
    #2;
    chk("ar_busy_pre", 32'(fu_busy),     32'h1);
    chk("ar_iv_pre",   32'(issue_valid), 32'h2);
    chk("ar_prd_pre",  32'(wb_prd),      32'd61);
    rst = 1'b1;
    #1;
    chk("ar_iv_rst",   32'(issue_valid), 32'h0);
    chk("ar_idx_rst",  32'(issue_idx),   32'h0);
    chk("ar_busy_rst", 32'(fu_busy),     32'h0);
    chk("ar_wb_rst",   32'(wb_valid),    32'h0);
    chk("ar_prd_rst",  32'(wb_prd),      32'h0);
    rst = 1'b0;
    clear_rs();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #2;
      chk("ar_no_wb",   32'(wb_valid), 32'h0);
      chk("ar_no_busy", 32'(fu_busy),  32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter NUM_RS, 16, reservation-station entries (power of two).
REQ-002 Parameter NUM_FU, 3, functional units: FU0 and FU1 are ALU, FU2 is MEM.
REQ-003 Parameter LAT_W, 3, width of the per-entry latency field.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  synchronous pipeline flush.
REQ-007 rs_valid  in  NUM_RS  entry occupied.
REQ-008 rs_ready  in  NUM_RS  both source operands ready.
REQ-009 rs_is_mem  in  NUM_RS  entry needs MEM unit (else ALU).
REQ-010 rs_lat  in  NUM_RS x LAT_W  execution latency, legal 1-4.
REQ-011 rs_prd  in  NUM_RS x 6  physical destination tag.
REQ-012 issue_valid  out  NUM_FU  grant to FU f this cycle.
REQ-013 issue_idx  out  NUM_FU x 4  RS index granted to FU f.
REQ-014 wb_valid  out  NUM_FU  FU f completes this cycle.
REQ-015 wb_prd  out  NUM_FU x 6  destination tag of completing op.
REQ-016 fu_busy  out  NUM_FU  FU f cannot accept an issue this cycle.

Function
REQ-017 Per FU: 3-bit counter cnt[f] and 6-bit tag register tag[f].
REQ-018 fu_free[f] = (cnt[f] <= 1); fu_busy[f] = ~fu_free[f].
REQ-019 Candidate = rs_valid & rs_ready; ALU candidates exclude rs_is_mem, MEM candidates include only rs_is_mem.
REQ-020 Grants are combinational, same cycle; the RS clears granted entries at the next clk edge.
REQ-021 ALU selection: first candidate at or after alu_ptr (wrapping past NUM_RS-1 to 0) goes to the lowest-numbered free ALU FU; the next candidate in the same circular order goes to the other ALU FU if it is free.
REQ-022 MEM selection: first MEM candidate at or after mem_ptr goes to FU2 if FU2 is free.
REQ-023 One entry is never granted to two FUs; issue_idx is 0 when issue_valid is low.
REQ-024 On issue to f: cnt[f] <= rs_lat (value 0 is treated as 1, values above 4 are clamped to 4); tag[f] <= rs_prd.
REQ-025 Without an issue: cnt[f] <= cnt[f] - 1 when nonzero, else it holds at 0.
REQ-026 wb_valid[f] = (cnt[f] == 1); wb_prd[f] = tag[f]; an op issued in cycle N with latency L writes back in cycle N+L.
REQ-027 Back-to-back: an FU may issue in the same cycle it writes back (cnt == 1).
REQ-028 alu_ptr <= last granted ALU index + 1 (mod NUM_RS); mem_ptr is handled likewise; pointers hold when there is no grant.
REQ-029 flush high: issue_valid and wb_valid are forced to 0 that cycle; at the edge cnt, tag, alu_ptr and mem_ptr are set to 0.
REQ-030 flush and candidates in the same cycle: flush wins and nothing issues.
REQ-031 No candidates or all FUs busy: outputs are idle and state only decrements.

Reset
REQ-032 rst asserted: cnt, tag, alu_ptr and mem_ptr go to 0 immediately, asynchronously.
REQ-033 During reset: issue_valid=0, issue_idx=0, wb_valid=0, wb_prd=0, fu_busy=0.
REQ-034 Reset mid-execution discards in-flight ops; no wb_valid is produced for them.
REQ-035 First grant is possible in the first cycle after rst deasserts.

Structure
REQ-036 NUM_RS, NUM_FU, FU index constants (FU_ALU0=0, FU_ALU1=1, FU_MEM=2) and an issue_t struct {valid, idx, prd} live in package rezzmaster.
REQ-037 One sub-module, rr_picker: a circular find-first over a NUM_RS mask from a pointer, returning a found flag and an index; it is instantiated for the ALU first pick, the ALU second pick (first pick masked out) and the MEM pick.

Verification
REQ-038 Reset, then entries 3 and 7 ALU-ready with lat 1 -> issue FU0=3, FU1=7 in the same cycle; wb_valid=3'b011 one cycle later with the matching tags.
REQ-039 Entry 5 MEM with lat 4 and prd 40, then entry 6 MEM ready -> entry 6 is granted 3 cycles later, in the cycle wb_valid[2]=1 with wb_prd=40.
REQ-040 Round-robin: entries 0, 1 and 2 ALU-ready and held, all lat 3 -> grants 0 and 1, then 2 once an ALU frees; alu_ptr wraps after index 15.
REQ-041 Flush while FU0 has cnt=3 and entry 9 is ready -> no issue and no wb that cycle; fu_busy=0 next cycle.
REQ-042 rst pulsed for 1 ns mid-operation -> all outputs 0 immediately; no stale wb_valid after release.
REQ-043 rs_lat=0 and rs_lat=7 on issued entries -> writebacks after 1 and 4 cycles respectively.
